// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits, LSB first, one stop bit.
// Optional even parity bit after the data, enabled by defining UART_RX_PARITY_EN.
// The received-byte port is named rx_byte because "byte" is a SystemVerilog keyword.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          sync1;
  logic          rxs;

`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // Receive FSM: start-bit qualification, mid-bit sampling, result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      rx_byte   <= 8'h00;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == MID) begin
            cnt <= '0;
            idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
            // A line that is already high again at mid start bit was a glitch.
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shift <= {rxs, shift[7:1]};
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            // Even parity: data ones plus parity bit must be even.
            par_bad <= (^shift) ^ rxs;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (!rxs) begin
              // Low stop bit wins over any parity problem.
              frame_err <= 1'b1;
              state     <= BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err <= 1'b1;
              state      <= IDLE;
`endif
            end else begin
              rx_byte <= shift;
              done    <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT=16.
// Table-driven frames, hand-written corner sequences and random frames
// compared against a frame-level reference model.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_BITS = 10 + (PAR_EN ? 1 : 0);

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       done, frame_err, parity_err, busy;

  int n_total = 0;
  int n_pass  = 0;
  int cyc = 0;
  int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, busy_cycles = 0;
  int done_t[$];
  logic [7:0] done_b[$];
  logic done_p = 1'b0, ferr_p = 1'b0, perr_p = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pflip;
    logic       exp_done;
    logic       exp_ferr;
    logic       exp_perr;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t vecs[8];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_byte(rx_byte), .done(done),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Output monitor: counts pulses, records done times/bytes, checks pulse rules.
  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cycles++;
    if (done || frame_err || parity_err) begin
      check("pulse_exclusive", int'(done) + int'(frame_err) + int'(parity_err), 1);
      check("pulse_single_cycle", int'(done && done_p) + int'(frame_err && ferr_p) +
            int'(parity_err && perr_p), 0);
    end
    if (done) begin
      done_cnt++;
      done_t.push_back(cyc);
      done_b.push_back(rx_byte);
    end
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
    done_p = done;
    ferr_p = frame_err;
    perr_p = parity_err;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // pflip inverts the correct even-parity bit (only sent when parity is built in).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ pflip);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int d0, f0, p0, n0, t0;
    logic [7:0] rd;
    logic rstop, rpf, exp_d, exp_f, exp_p;
    logic [7:0] model_byte;

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_byte", int'(rx_byte), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pulses", int'(done) + int'(frame_err) + int'(parity_err), 0);
    rst = 1'b0;
    idle(5);

    // Single frame 0x55, latency and busy release
    d0 = done_cnt; f0 = ferr_cnt; n0 = done_t.size();
    t0 = cyc;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(3);
    check("f55_done_count", done_cnt - d0, 1);
    check("f55_ferr_count", ferr_cnt - f0, 0);
    check("f55_byte", int'(rx_byte), 8'h55);
    check("f55_busy_after", int'(busy), 0);
    if (done_t.size() > n0)
      check_range("f55_latency", done_t[n0] - t0, 2 + CPB/2 + (FRAME_BITS-1)*CPB - 2,
                  2 + CPB/2 + (FRAME_BITS-1)*CPB + 2);
    else
      check("f55_latency_seen", done_t.size() - n0, 1);

    // Back-to-back 0xA3, 0x0F with no idle gap
    d0 = done_cnt; n0 = done_t.size();
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(3);
    check("b2b_done_count", done_cnt - d0, 2);
    if (done_t.size() >= n0 + 2) begin
      check_range("b2b_spacing", done_t[n0+1] - done_t[n0], FRAME_BITS*CPB - 2, FRAME_BITS*CPB + 2);
      check("b2b_byte0", int'(done_b[n0]), 8'hA3);
      check("b2b_byte1", int'(done_b[n0+1]), 8'h0F);
    end
    check("b2b_byte_hold", int'(rx_byte), 8'h0F);

    // Start-bit glitch: 4 cycles low
    d0 = done_cnt; f0 = ferr_cnt;
    busy_cycles = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check_range("glitch_busy_cycles", busy_cycles, 1, 10);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_byte", int'(rx_byte), 8'h0F);

    // Framing error with line held low (break)
    send_frame(8'h55, 1'b1, 1'b0);
    idle(4);
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    check("brk_busy_low", int'(busy), 1);
    check("brk_ferr_count", ferr_cnt - f0, 1);
    check("brk_no_done", done_cnt - d0, 0);
    check("brk_byte", int'(rx_byte), 8'h55);
    idle(5);
    check("brk_busy_released", int'(busy), 0);

    // Reset in data bit 3 of 0xFF, then a clean frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("rstmid_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("rstmid_byte", int'(rx_byte), 0);
    check("rstmid_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    d0 = done_cnt;
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(3);
    check("rstmid_next_done", done_cnt - d0, 1);
    check("rstmid_next_byte", int'(rx_byte), 8'h3C);

    // Table-driven frames
    vecs[0] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80};
    vecs[5] = '{8'hC3, 1'b1, 1'b1, ~PAR_EN, 1'b0, PAR_EN, PAR_EN ? 8'h80 : 8'hC3};
    vecs[6] = '{8'h96, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, PAR_EN ? 8'h80 : 8'hC3};
    vecs[7] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7E};
    for (int v = 0; v < 8; v++) begin
      d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].pflip);
      idle(20);
      check($sformatf("vec%0d_done", v), done_cnt - d0, int'(vecs[v].exp_done));
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, int'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_perr", v), perr_cnt - p0, int'(vecs[v].exp_perr));
      check($sformatf("vec%0d_byte", v), int'(rx_byte), int'(vecs[v].exp_byte));
    end

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 needs parity bit 1
    d0 = done_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(5);
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_no_done", done_cnt - d0, 0);
    check("par_bad_byte", int'(rx_byte), 8'h7E);
    d0 = done_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(5);
    check("par_ok_done", done_cnt - d0, 1);
    check("par_ok_no_perr", perr_cnt - p0, 0);
    check("par_ok_byte", int'(rx_byte), 8'h07);
`endif

    // Random frames against a frame-level reference model
    model_byte = rx_byte;
    for (int k = 0; k < 30; k++) begin
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rpf   = PAR_EN && ($urandom_range(0, 3) == 0);
      exp_f = !rstop;
      exp_p = rstop && rpf;
      exp_d = rstop && !rpf;
      if (exp_d) model_byte = rd;
      d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(rd, rstop, rpf);
      check($sformatf("rnd%0d_done", k), done_cnt - d0, int'(exp_d));
      check($sformatf("rnd%0d_ferr", k), ferr_cnt - f0, int'(exp_f));
      check($sformatf("rnd%0d_perr", k), perr_cnt - p0, int'(exp_p));
      check($sformatf("rnd%0d_byte", k), int'(rx_byte), int'(model_byte));
      idle(rstop ? $urandom_range(0, 3) : 4 + $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal values are 8 or greater.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line (UART_TXD_IN); idle high.
REQ-005 SHALL have port byte  output  8  last correctly received data byte.
REQ-006 SHALL have port done  output  1  single-cycle pulse: byte just updated.
REQ-007 SHALL have port frame_err  output  1  single-cycle pulse: stop bit sampled low.
REQ-008 SHALL have port parity_err  output  1  single-cycle pulse: parity mismatch; tied 0 when parity is compiled out.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1; only the synchronized value (rxs) is used downstream.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK, plus a bit counter of width $clog2(CLKS_PER_BIT)+1 and a 3-bit bit index.
REQ-012 IDLE: rxs==0 -> START; bit counter cleared.
REQ-013 START: at counter == CLKS_PER_BIT/2-1 (start-bit midpoint), rxs==1 -> IDLE with no output pulse (glitch reject); rxs==0 -> DATA with counter and index cleared.
REQ-014 DATA: sample rxs each time counter reaches CLKS_PER_BIT-1, then clear counter; LSB first into shift register; after index 7 -> PARITY if enabled, else STOP.
REQ-015 STOP: sample at counter == CLKS_PER_BIT-1; rxs==1 and no pending parity error -> byte <= shift register and done=1 in the same cycle, then IDLE.
REQ-016 STOP with rxs==0 -> frame_err=1 for one cycle, byte unchanged, no done, -> BREAK.
REQ-017 BREAK: remain until rxs==1, then IDLE; no outputs asserted.
REQ-018 done, frame_err, and parity_err SHALL never be high longer than one cycle and SHALL never be high simultaneously.
REQ-019 byte SHALL hold its value between done pulses.
REQ-020 Back-to-back frames (start bit immediately after stop midpoint) SHALL be received without loss; IDLE re-arms on the cycle after STOP.
REQ-021 Latency from rx falling edge at the pin to done: 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity), tolerance +-2 cycles.

Reset
REQ-022 rst SHALL force the following immediately, regardless of state: state=IDLE, counter=0, index=0, shift=0x00, byte=0x00, done=0, frame_err=0, parity_err=0, busy=0, synchronizer=1.
REQ-023 Reset mid-frame SHALL discard the partial byte; the first frame after reset release SHALL decode normally.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after data at counter == CLKS_PER_BIT-1, then -> STOP.
REQ-025 With UART_RX_PARITY_EN, a mismatch SHALL set parity_err=1 at the STOP sample cycle, with no done and byte unchanged. If the stop bit is also low, frame_err takes precedence and parity_err stays 0.
REQ-026 Macro UART_RX_PARITY_EN undefined: PARITY state is unreachable (DATA -> STOP) and parity_err is constant 0.

Verification (bench CLKS_PER_BIT=16)
REQ-027 Frame 0x55, stop=1 -> exactly one done pulse, byte=0x55, frame_err=0, busy falls the following cycle.
REQ-028 Frames 0xA3 then 0x0F with zero idle gap -> two done pulses 160 +-2 cycles apart, byte=0xA3 then 0x0F.
REQ-029 rx low for 4 cycles then high -> busy for at most 10 cycles, no done, no frame_err, byte unchanged.
REQ-030 Prior byte 0x55, then frame 0x81 with stop=0 and rx held low 50 cycles -> one frame_err pulse, byte stays 0x55, busy high until rx returns high.
REQ-031 rst pulsed during data bit 3 of 0xFF -> byte=0x00 and busy=0 immediately; next frame 0x3C -> done, byte=0x3C.
REQ-032 UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> parity_err pulse, no done; 0x07 with parity bit 1 -> done, byte=0x07.
